// File: rtl/jellyvl_stream_fifo_if.sv
// Stream bus for jellyvl_stream_fifo: write side, read side and fill-level status.
interface jellyvl_stream_fifo_if #(
  parameter type         t_data   = logic [8-1:0],
  parameter int unsigned PTR_BITS = 4
);
  t_data             s_data;
  logic              s_valid;
  logic              s_ready;
  t_data             m_data;
  logic              m_valid;
  logic              m_ready;
  logic [PTR_BITS:0] data_count;
  logic [PTR_BITS:0] free_count;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, data_count, free_count
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, data_count, free_count
  );
endinterface

// File: rtl/jellyvl_stream_fifo.sv
// First-word-fall-through stream FIFO with registered occupancy count and
// combinational head read; sits downstream of jellyvl_data_delay.
module jellyvl_stream_fifo #(
  parameter type         t_data    = logic [8-1:0],
  parameter int unsigned PTR_BITS  = 4,
  parameter t_data       INIT_DATA = 'x
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cke,
  jellyvl_stream_fifo_if.slave    bus
);
  localparam int unsigned       DEPTH   = 2 ** PTR_BITS;
  localparam logic [PTR_BITS:0] DEPTH_C = {1'b1, {PTR_BITS{1'b0}}};

  t_data                mem_q [DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]    count_q,  count_d;

  logic s_ready;
  logic m_valid;
  logic push;
  logic pop;

  // Full never accepts, even with a simultaneous pop, so s_ready stays registered-only.
  assign s_ready = !reset && (count_q != DEPTH_C);
  assign m_valid = (count_q != '0);
  assign push    = cke && bus.s_valid && s_ready;
  assign pop     = cke && m_valid && bus.m_ready;

  assign bus.s_ready    = s_ready;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = m_valid ? mem_q[rd_ptr_q] : INIT_DATA;
  assign bus.data_count = count_q;
  assign bus.free_count = DEPTH_C - count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_BITS+1)'(1);
      2'b01:   count_d = count_q - (PTR_BITS+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; push already excludes reset cycles via s_ready.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.s_data;
  end
endmodule

// File: tb/tb_jellyvl_stream_fifo.sv
// Directed bench for jellyvl_stream_fifo with DEPTH=4 and a visible INIT_DATA.
module tb_jellyvl_stream_fifo;
  localparam int unsigned PB   = 2;
  localparam logic [7:0]  INIT = 8'hEE;

  logic clk = 1'b0;
  logic reset;
  logic cke;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jellyvl_stream_fifo_if #(.t_data(logic [7:0]), .PTR_BITS(PB)) bus ();

  jellyvl_stream_fifo #(
    .t_data    (logic [7:0]),
    .PTR_BITS  (PB),
    .INIT_DATA (INIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cke   (cke),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    tick();
    bus.s_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    cke         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.m_ready = 1'b0;
    tick();
    tick();
    chk("rst_s_ready",    32'(bus.s_ready),    32'd0);
    chk("rst_m_valid",    32'(bus.m_valid),    32'd0);
    chk("rst_data_count", 32'(bus.data_count), 32'd0);
    chk("rst_free_count", 32'(bus.free_count), 32'd4);
    chk("rst_m_data",     32'(bus.m_data),     32'(INIT));
    reset = 1'b0;
    tick();
    chk("rel_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rel_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rel_m_data",  32'(bus.m_data),  32'(INIT));

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      push_word(8'(8'h11 + i));
      chk("fill_count", 32'(bus.data_count), 32'(i + 1));
    end
    chk("full_s_ready", 32'(bus.s_ready),    32'd0);
    chk("full_free",    32'(bus.free_count), 32'd0);
    chk("full_head",    32'(bus.m_data),     32'h11);
    push_word(8'h55);
    chk("full_reject_count", 32'(bus.data_count), 32'd4);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(bus.m_valid), 32'd1);
      chk("drain_data",  32'(bus.m_data),  32'(8'h11 + i));
      tick();
    end
    chk("drained_valid", 32'(bus.m_valid),    32'd0);
    chk("drained_count", 32'(bus.data_count), 32'd0);
    chk("drained_data",  32'(bus.m_data),     32'(INIT));
    bus.m_ready = 1'b0;

    // Empty push: no bypass
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    #1;
    chk("empty_push_same_cycle_valid", 32'(bus.m_valid), 32'd0);
    tick();
    bus.s_valid = 1'b0;
    chk("empty_push_next_valid", 32'(bus.m_valid),    32'd1);
    chk("empty_push_next_data",  32'(bus.m_data),     32'hA5);
    chk("empty_push_count",      32'(bus.data_count), 32'd1);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk("empty_pop_count", 32'(bus.data_count), 32'd0);

    // Full with pop: first cycle pops only, then push and pop together
    for (int i = 0; i < 4; i++) push_word(8'(8'h21 + i));
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h25;
    bus.m_ready = 1'b1;
    #1;
    chk("fullpop_s_ready", 32'(bus.s_ready), 32'd0);
    tick();
    chk("fullpop_count1", 32'(bus.data_count), 32'd3);
    chk("fullpop_head1",  32'(bus.m_data),     32'h22);
    chk("fullpop_ready1", 32'(bus.s_ready),    32'd1);
    tick();
    bus.s_valid = 1'b0;
    chk("fullpop_count2", 32'(bus.data_count), 32'd3);
    chk("fullpop_head2",  32'(bus.m_data),     32'h23);
    for (int i = 0; i < 3; i++) begin
      chk("fullpop_drain", 32'(bus.m_data), 32'(8'h23 + i));
      tick();
    end
    chk("fullpop_empty", 32'(bus.m_valid), 32'd0);
    bus.m_ready = 1'b0;

    // Streaming with repeated pointer wrap
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.s_data = 8'(i);
      tick();
      chk("stream_data",  32'(bus.m_data),     32'(i));
      chk("stream_valid", 32'(bus.m_valid),    32'd1);
      chk("stream_count", 32'(bus.data_count), 32'd1);
    end
    bus.s_valid = 1'b0;
    tick();
    chk("stream_end_count", 32'(bus.data_count), 32'd0);
    bus.m_ready = 1'b0;

    // cke gating
    push_word(8'h31);
    push_word(8'h32);
    cke = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = i[0];
      bus.m_ready = ~i[0];
      bus.s_data  = 8'(8'h40 + i);
      tick();
      chk("cke_count",   32'(bus.data_count), 32'd2);
      chk("cke_head",    32'(bus.m_data),     32'h31);
      chk("cke_m_valid", 32'(bus.m_valid),    32'd1);
      chk("cke_s_ready", 32'(bus.s_ready),    32'd1);
    end
    cke         = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    #1;
    chk("cke_resume0", 32'(bus.m_data), 32'h31);
    tick();
    chk("cke_resume1", 32'(bus.m_data), 32'h32);
    tick();
    chk("cke_resume_empty", 32'(bus.m_valid), 32'd0);
    bus.m_ready = 1'b0;

    // Mid-stream reset with a push pending
    push_word(8'h51);
    push_word(8'h52);
    push_word(8'h53);
    chk("prerst_count", 32'(bus.data_count), 32'd3);
    reset       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h77;
    #1;
    chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    tick();
    reset       = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    chk("postrst_m_valid", 32'(bus.m_valid),    32'd0);
    chk("postrst_count",   32'(bus.data_count), 32'd0);
    chk("postrst_free",    32'(bus.free_count), 32'd4);
    chk("postrst_s_ready", 32'(bus.s_ready),    32'd1);
    push_word(8'h61);
    push_word(8'h62);
    chk("postrst_fill_count", 32'(bus.data_count), 32'd2);
    bus.m_ready = 1'b1;
    #1;
    chk("postrst_out0", 32'(bus.m_data), 32'h61);
    tick();
    chk("postrst_out1", 32'(bus.m_data), 32'h62);
    tick();
    chk("postrst_empty", 32'(bus.m_valid), 32'd0);
    bus.m_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jellyvl_stream_fifo.md
# jellyvl_stream_fifo

Synchronous first-word-fall-through FIFO on a valid/ready stream, placed directly downstream of `jellyvl_data_delay`. It absorbs the delay line's output so that downstream backpressure does not stall the pipeline immediately. It also gives the controlling logic fill-level visibility through `data_count` and `free_count`. All state is in one clock domain.

## Interface
Parameters:
- `t_data`, default `logic [8-1:0]`: payload type.
- `PTR_BITS`, default 4: address width. DEPTH = 2**PTR_BITS entries. Legal range 1..16.
- `INIT_DATA`, default `'x`: value driven on `m_data` while the FIFO is empty and after reset.

Ports:
- `clk`, input, 1: clock. All logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `cke`, input, 1: clock enable. When low, all state holds and no transfer occurs.
- `s_data`, input, t_data: write payload.
- `s_valid`, input, 1: write request.
- `s_ready`, output, 1: FIFO can accept a word.
- `m_data`, output, t_data: head-of-queue payload.
- `m_valid`, output, 1: head word present.
- `m_ready`, input, 1: consumer accepts the head word.
- `data_count`, output, PTR_BITS+1: number of stored words, 0..DEPTH.
- `free_count`, output, PTR_BITS+1: DEPTH − data_count.

## Operation
- Storage: DEPTH-entry array `mem`, with PTR_BITS-bit `wr_ptr` and `rd_ptr`.
  - Both pointers wrap naturally from DEPTH−1 to 0.
  - Occupancy is held in a registered `count` of PTR_BITS+1 bits. Full/empty is never derived from pointer equality.
- Status signals:
  - `s_ready` = !reset && (count != DEPTH).
  - `m_valid` = (count != 0).
  - `m_data` = mem[rd_ptr] when `m_valid`, else INIT_DATA.
- Transfer conditions:
  - push = cke && s_valid && s_ready.
  - pop = cke && m_valid && m_ready.
- On push: mem[wr_ptr] <= s_data, and wr_ptr increments.
- On pop: rd_ptr increments.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Simultaneous push and pop at a non-full, non-empty level: both happen and count is unchanged.
- Full (count == DEPTH): `s_ready` = 0 even if `m_ready` = 1 in the same cycle. There is no write-through-on-pop. This keeps `s_ready` a function of registered state only (plus reset).
- Empty (count == 0): `m_valid` = 0. A push in the same cycle does not bypass to the output; the word appears the next cycle.
- `s_data` is ignored when push is 0.
- `cke` low: pointers, count and mem hold. `s_ready` and `m_valid` still reflect the current state, but no handshake completes.
- Reset: wr_ptr = rd_ptr = 0 and count = 0. Memory contents are not cleared. Reset mid-operation discards all queued words. A push asserted during the reset cycle is dropped.
- Upstream contract: `jellyvl_data_delay` only drops `m_valid` when `m_ready` is high, so `s_valid` is stable while `s_ready` = 0. The FIFO does not depend on this contract.

## Timing
- Write-to-read latency is 1 cycle. A word pushed at edge N is visible on `m_data`/`m_valid` after edge N, i.e. in cycle N+1.
- Throughput is 1 word per cycle sustained when neither full nor empty.
- `s_ready`, `m_valid`, `data_count` and `free_count` are registered-state functions, with `reset` additionally gating `s_ready`.
- `m_data` is a combinational read of `mem` at `rd_ptr` (distributed-RAM style).
- Output values during and after reset:
  - While `reset` = 1: `s_ready` = 0, `m_valid` = 0, `data_count` = 0, `free_count` = DEPTH, `m_data` = INIT_DATA.
  - First cycle after reset release: `s_ready` = 1, all other outputs unchanged.

## Test plan
- **Fill and drain** (PTR_BITS=2): hold `m_ready`=0 and push 0x11..0x14.
  - `s_ready` falls after the 4th push; `data_count`=4, `free_count`=0.
  - A 5th `s_valid` is not accepted.
  - Then `m_ready`=1: out 0x11,0x12,0x13,0x14 on consecutive cycles, then `m_valid`=0.
- **Streaming**: `s_valid`=`m_ready`=1 continuously with data 0..99.
  - Output 0..99 in order, each one cycle after its push.
  - `data_count` stays 1 after the first cycle.
  - Exercises pointer wrap repeatedly.
- **Full with pop**: at count=4, assert `m_ready`=1 and `s_valid`=1.
  - Cycle 1: pop only, count becomes 3.
  - Next cycle: push and pop, count stays 3.
- **Empty push**: at count=0, push 0xA5. `m_valid`=0 in that cycle, then `m_valid`=1 and `m_data`=0xA5 in the next.
- **cke gating**: with count=2, hold `cke`=0 for 5 cycles while toggling `s_valid`/`m_ready`.
  - Count, `m_data` and order are unchanged.
  - Resume with `cke`=1: normal output.
- **Mid-stream reset**: with count=3, pulse `reset` for 1 cycle while `s_valid`=1.
  - Next cycle: `m_valid`=0, `data_count`=0, `s_ready`=1.
  - Subsequent pushes output correctly.
